// File: rtl/int_adder_tree_acc_pkg.sv
// Shared types and clamp constants for the adder-tree accumulator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: acc_state_t (IDLE/ACCUM), obuf_state_t (EMPTY/FULL),
//           acc_max_of()/acc_min_of() signed clamp limits for a given width.
package int_adder_tree_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } obuf_state_t;

  // Largest signed value representable in w bits, zero-extended to 64 bits.
  function automatic logic [63:0] acc_max_of(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Smallest signed value in w bits; only the low w bits are meaningful
  // (a one in bit w-1 followed by zeros).
  function automatic logic [63:0] acc_min_of(input int w);
    return ~acc_max_of(w);
  endfunction

endpackage

// File: rtl/int_adder_tree_acc_if.sv
// Bundle of the accumulator's data-path and handshake signals.
// Latency: n/a (wiring only).
// Backpressure: out_ready only; the input side has none.
// Ports: in_data/in_valid/clear (tree side), out_data/out_valid/out_ready
//        (consumer side), overflow (sticky drop flag), beat_cnt (progress).
// Modports: master drives the inputs and the ready, slave is the accumulator.
interface int_adder_tree_acc_if #(
  parameter int IN_WIDTH  = 20,
  parameter int ACC_WIDTH = 32,
  parameter int NUM_BEATS = 8
);
  localparam int CNT_W = $clog2(NUM_BEATS + 1);

  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_valid;
  logic                 clear;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 overflow;
  logic [CNT_W-1:0]     beat_cnt;

  modport master (
    output in_data, in_valid, clear, out_ready,
    input  out_data, out_valid, overflow, beat_cnt
  );

  modport slave (
    input  in_data, in_valid, clear, out_ready,
    output out_data, out_valid, overflow, beat_cnt
  );

endinterface

// File: rtl/int_adder_tree_acc_sat_add.sv
// Combinational signed adder used by the accumulator, optionally saturating.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a, b (WIDTH-bit two's complement operands), sum (WIDTH-bit result).
// Build option: INT_TREE_ACC_SATURATE_EN defined -> clamp to the signed range;
//               undefined -> wrap modulo 2^WIDTH. WIDTH must be >= 2.
module int_acc_sat_add
  import int_adder_tree_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

`ifdef INT_TREE_ACC_SATURATE_EN
  localparam logic [63:0]      MAX64   = acc_max_of(WIDTH);
  localparam logic [63:0]      MIN64   = acc_min_of(WIDTH);
  localparam logic [WIDTH-1:0] SAT_MAX = MAX64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_MIN = MIN64[WIDTH-1:0];

  logic [WIDTH:0] full;
  logic           carry_in_sign;
  logic           carry_out_sign;
  logic           ovf;

  assign full = {1'b0, a} + {1'b0, b};
  // Sum bit = a ^ b ^ carry-in, so the carry into the sign bit is recoverable
  // from the sign bits without a second narrower adder.
  assign carry_in_sign  = a[WIDTH-1] ^ b[WIDTH-1] ^ full[WIDTH-1];
  assign carry_out_sign = full[WIDTH];
  assign ovf            = carry_in_sign ^ carry_out_sign;

  // On overflow both operands share a sign; clamp toward that sign.
  assign sum = ovf ? (a[WIDTH-1] ? SAT_MIN : SAT_MAX) : full[WIDTH-1:0];
`else
  assign sum = a + b;
`endif

endmodule

// File: rtl/int_adder_tree_acc.sv
// Sums NUM_BEATS valid adder-tree root words into one wide result, one-entry out buffer.
// Latency: out_valid rises 1 cycle after the completing beat's edge.
// Backpressure: none on input (every beat absorbed); full buffer + !out_ready drops result, sets overflow.
// Ports: clk, rst (async active-high), bus (int_adder_tree_acc_if.slave):
//        in_data/in_valid/clear in, out_data/out_valid/out_ready, overflow, beat_cnt.
// Build option: INT_TREE_ACC_SATURATE_EN selects saturating adds (see int_acc_sat_add).
// Parameter constraints: ACC_WIDTH >= IN_WIDTH, ACC_WIDTH >= 2, NUM_BEATS >= 1;
// the interface instance must carry the same parameter values.
module int_adder_tree_acc
  import int_adder_tree_pkg::*;
#(
  parameter int IN_WIDTH  = 20,
  parameter int ACC_WIDTH = 32,
  parameter int NUM_BEATS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  int_adder_tree_acc_if.slave  bus
);

  localparam int               CNT_W    = $clog2(NUM_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

  acc_state_t           state_q, state_d;
  obuf_state_t          obuf_q, obuf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_WIDTH-1:0] in_sext;
  logic [ACC_WIDTH-1:0] add_sum;
  logic [ACC_WIDTH-1:0] result;
  logic                 complete;

  assign in_sext = ACC_WIDTH'($signed(bus.in_data));

  int_acc_sat_add #(
    .WIDTH (ACC_WIDTH)
  ) u_add (
    .a   (acc_q),
    .b   (in_sext),
    .sum (add_sum)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    complete = 1'b0;
    result   = add_sum;

    if (bus.clear) begin
      // Abort wins over a same-cycle beat: that beat is discarded.
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (bus.in_valid) begin
      unique case (state_q)
        IDLE: begin
          if (NUM_BEATS == 1) begin
            // Every beat completes a group; the word itself is the result.
            complete = 1'b1;
            result   = in_sext;
          end else begin
            // First beat loads rather than adds, so stale contents never leak in.
            acc_d   = in_sext;
            cnt_d   = CNT_W'(1);
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (cnt_q == LAST_CNT) begin
            complete = 1'b1;
            result   = add_sum;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            acc_d = add_sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end
      endcase
    end
  end

  // ------------------------------------------------------ output buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obuf_q     <= EMPTY;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      obuf_q     <= obuf_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    obuf_d     = obuf_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;

    if (complete) begin
      // A pop in the same cycle frees the slot, so the new result fits.
      if ((obuf_q == EMPTY) || bus.out_ready) begin
        obuf_d     = FULL;
        out_data_d = result;
      end else begin
        ovf_d = 1'b1;
      end
    end else if ((obuf_q == FULL) && bus.out_ready) begin
      obuf_d = EMPTY;
    end
  end

  // All outputs come straight from flops.
  assign bus.out_valid = (obuf_q == FULL);
  assign bus.out_data  = out_data_q;
  assign bus.overflow  = ovf_q;
  assign bus.beat_cnt  = cnt_q;

endmodule

// File: doc/int_adder_tree_acc.md
# int_adder_tree_acc

Downstream accumulator for the integer adder tree. It consumes the single root word of the final tree layer, together with the tree's pipelined `extra_bit_out` used as a valid flag. It sums `NUM_BEATS` valid root words into one wide result and presents that result on a valid/ready output. The tree cannot stall, so the block buffers one finished result and flags any loss of data.

## Interface
- `IN_WIDTH`, default 20: root word width, two's complement.
- `ACC_WIDTH`, default 32: accumulator and result width; must be `>= IN_WIDTH`.
- `NUM_BEATS`, default 8: valid beats per result; must be `>= 1`.
- `clk`, input, 1: single clock; everything is rising-edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `clear`, input, 1: synchronous abort of the partial sum.
- `in_data`, input, `IN_WIDTH`: adder-tree root word.
- `in_valid`, input, 1: beat qualifier, driven by the tree's `extra_bit_out`.
- `out_data`, output, `ACC_WIDTH`: finished sum.
- `out_valid`, output, 1: result held in the output buffer.
- `out_ready`, input, 1: consumer accepts the result.
- `overflow`, output, 1: sticky flag; a result was dropped.
- `beat_cnt`, output, `$clog2(NUM_BEATS+1)`: beats absorbed into the current partial sum.

## Operation
- Input is sign-extended to `ACC_WIDTH`.
- No input backpressure exists; every `in_valid` beat is absorbed.
- Accumulator FSM:
  - IDLE (`beat_cnt = 0`):
    - a valid beat loads `acc = sext(in_data)`. There is no add with stale contents.
    - The FSM moves to ACCUM with count 1.
  - ACCUM:
    - a valid beat performs `acc += sext(in_data)` and increments the count.
    - On beat number `NUM_BEATS`, the final sum `acc + sext(in_data)` goes to the output buffer and the FSM returns to IDLE with count 0.
  - `NUM_BEATS = 1`: every valid beat is a completing beat, taken straight from IDLE.
- Output buffer, one entry, states EMPTY and FULL:
  - A completing beat writes the buffer when it is EMPTY, or when it is FULL and `out_ready` is high in the same cycle (simultaneous pop and push). In both cases there is no overflow and the new result is shown.
  - A completing beat while the buffer is FULL with `out_ready` low drops the new result, keeps the old one, and sets `overflow`.
  - A handshake (`out_valid && out_ready`) with no completing beat empties the buffer.
- `out_data` is stable while `out_valid && !out_ready`.
- `clear`:
  - discards the partial sum and forces count 0 / IDLE.
  - Any `in_valid` beat in the same cycle is dropped.
  - The output buffer and `overflow` are untouched.
- `overflow` is cleared only by `rst`.
- Reset mid-operation: the partial sum and the buffered result are lost, and no result is emitted for beats before reset.

## Timing
- Reset values:
  - `out_valid = 0`
  - `out_data = 0`
  - `overflow = 0`
  - `beat_cnt = 0`
  - accumulator 0, FSM IDLE.
- Latency: `out_valid` rises on the cycle after the completing beat's edge, i.e. 1 cycle.
- Throughput: one result every `NUM_BEATS` valid cycles, provided the consumer accepts within `NUM_BEATS` cycles of `out_valid`.
- Gaps in `in_valid` are allowed anywhere and do not change the result.
- `out_ready` may be high while `out_valid` is low; this has no effect.
- The outputs are combinational from no input. `out_valid` may not depend on `out_ready`.

## Configuration
- `INT_TREE_ACC_SATURATE_EN`:
  - Defined: each add saturates to the signed `ACC_WIDTH` range, `[-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]`.
  - Undefined: adds wrap modulo `2^ACC_WIDTH`.
- Overflow detection compares the carry into and out of the sign bit. It is used only when the macro is defined.
- Saturation never sets `overflow`; that flag is reserved for dropped results.

## Structure
- Shared package `int_adder_tree_pkg` holds:
  - the FSM enum `acc_state_t` (IDLE, ACCUM);
  - the buffer enum `obuf_state_t` (EMPTY, FULL);
  - the `ACC_WIDTH` clamp constants as functions of the width.
- One sub-module, `int_acc_sat_add`: combinational signed adder of width `ACC_WIDTH`. Saturation is compiled under the macro.
- The counter, FSM and buffer live in the top module.

## Test plan
- Accumulate: `NUM_BEATS=4`, inputs 1, 2, 3, 4 on consecutive cycles, `out_ready=1` -> `out_valid` for exactly one cycle, one cycle after beat 4, with `out_data=10`.
- Signed sum with gaps: inputs -5, 3, -1, 2 with idle cycles between beats -> `out_data=32'hFFFFFFFF`, `beat_cnt` sequence 1, 2, 3, 0.
- Drop on full buffer: `out_ready=0`, two full groups (sums 10 and 26) -> `out_data` stays 10, `overflow=1` after the second group's last beat. Then `out_ready=1` -> `out_valid` drops after one cycle.
- Simultaneous pop and push: the buffer holds 10, `out_ready` rises in the same cycle as the completing beat of a group summing to 26 -> `out_data=26`, `out_valid` stays high, `overflow=0`.
- Saturation: `IN_WIDTH=8`, `ACC_WIDTH=8`, inputs 100, 100, 0, 0 -> `out_data=127` with `INT_TREE_ACC_SATURATE_EN` defined, and -56 without it.
- Clear and reset: `clear` after 2 beats, then inputs 1, 1, 1, 1 -> result 4. Separately, assert `rst` after 3 beats -> all outputs 0 immediately and no result emitted.
